// File: rtl/dlx_pipe_pkg.sv
// dlx_pipe_pkg: shared pipeline-stage state encoding and MEM/WB bundle layout
package dlx_pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  typedef enum logic [1:0] {EMPTY = ST_EMPTY, BUSY = ST_BUSY, FULL = ST_FULL} state_t;
  localparam int RW_W         = 5;
  localparam int ALU_DATA_W   = 32;
  localparam int MEM_DATA_W   = 32;
  localparam int WB_CTRL_W    = 2;
  localparam int RW_LSB       = 0;
  localparam int ALU_DATA_LSB = RW_LSB + RW_W;
  localparam int MEM_DATA_LSB = ALU_DATA_LSB + ALU_DATA_W;
  localparam int WB_CTRL_LSB  = MEM_DATA_LSB + MEM_DATA_W;
  localparam int MEMWB_W      = WB_CTRL_LSB + WB_CTRL_W;
  function automatic logic [MEMWB_W-1:0] pack_memwb(
    input logic [WB_CTRL_W-1:0]  ctrl,
    input logic [MEM_DATA_W-1:0] mem,
    input logic [ALU_DATA_W-1:0] alu,
    input logic [RW_W-1:0]       rw
  );
    return {ctrl, mem, alu, rw};
  endfunction
endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: payload register with async active-low reset, load enable and sync clear
module pipe_data_reg #(
  parameter int WIDTH = 71,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over load so a squashed stage never captures new data
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RESET_VAL;
    else if (clr) q <= RESET_VAL;
    else if (ld) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional skid buffer, flush and stall counter
module pipe_stage_reg
  import dlx_pipe_pkg::*;
#(
  parameter int WIDTH = 71,
  parameter int SKID = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);
  state_t st, st_nx;
  logic ov_q, ir_q, in_fire, out_fire, main_ld, skid_ld, clr;
  logic [WIDTH-1:0] skid_q, main_d;
  assign in_ready  = (SKID != 0) ? ir_q : (!ov_q | out_ready);
  assign out_valid = ov_q;
  assign in_fire   = in_valid & in_ready & !flush;
  assign out_fire  = ov_q & out_ready;
  assign clr       = flush & (CLEAR_ON_FLUSH != 0);
  assign main_d    = (st == FULL) ? skid_q : in_data;
  // next state and register load enables; flush overrides everything
  always_comb begin
    st_nx   = st;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    if (flush) st_nx = EMPTY;
    else if (st == FULL) begin
      st_nx   = out_fire ? BUSY : FULL;
      main_ld = out_fire;
    end else if (in_fire & (st == EMPTY | out_fire)) begin
      st_nx   = BUSY;
      main_ld = 1'b1;
    end else if (in_fire) begin
      st_nx   = FULL;
      skid_ld = 1'b1;
    end else if (out_fire) st_nx = EMPTY;
  end
  // state, valid and ready flops; ready is registered so it never sees out_ready
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st   <= EMPTY;
      ov_q <= 1'b0;
      ir_q <= 1'b1;
    end else begin
      st   <= st_nx;
      ov_q <= st_nx != EMPTY;
      ir_q <= st_nx != FULL;
    end
  // saturating count of cycles where downstream holds off a valid bundle
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cnt <= '0;
    else if (stall_clr) stall_cnt <= '0;
    else if (ov_q & !out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .reset(reset), .ld(main_ld), .clr(clr), .d(main_d), .q(out_data)
  );
  if (SKID != 0) begin : g_skid
    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk(clk), .reset(reset), .ld(skid_ld), .clr(clr), .d(in_data), .q(skid_q)
    );
  end else begin : g_noskid
    assign skid_q = RESET_VAL;
  end
endmodule
